// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-cell arbiter slice.
//   DEFAULT_* : default widths/depths for the shared 32x32 multiplier cell
//   mul_tag_t : issue tag carried alongside an op through the cell latency
package mul_arb_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_NUM_REQ     = 2;
  localparam int unsigned DEFAULT_MUL_LATENCY = 1;
  localparam int unsigned MAX_REQ             = 8;

  // Index field sized for the largest supported requester count so one
  // typedef serves every NUM_REQ instantiation.
  localparam int unsigned TAG_IDX_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } mul_tag_t;

endpackage

// File: rtl/mul_cell_arbiter_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
//   clk, reset  : clock, async active-high reset (pointer -> N-1)
//   eligible    : per-requester request vector
//   update      : advance pointer to the current winner
//   grant       : one-hot winner (zero when nothing eligible)
//   grant_idx   : binary index of the winner
//   grant_valid : some requester won
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         eligible,
  input  logic                 update,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last_grant;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!grant_valid && eligible[cand_idx]) begin
        grant_valid      = 1'b1;
        grant_idx        = cand_idx;
        grant[cand_idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IW'(N - 1);
    end else if (update && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one pipelined multiplier cell between NUM_REQ requesters.
//   req_valid/req_ready/req_src1/req_src2 : request side, one op per requester
//   rsp_valid/rsp_ready/rsp_result        : held per-requester results
//   mul_src1/mul_src2 -> cell, mul_result <- cell (MUL_LATENCY cycles later)
//   busy                                  : requester has an op in flight/held
module mul_cell_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int unsigned DATA_W      = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_result,
  output logic [NUM_REQ-1:0]        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  // One stage for the operand register plus one per cell stage.
  localparam int unsigned DEPTH = MUL_LATENCY + 1;

  logic [NUM_REQ-1:0]             eligible;
  logic [NUM_REQ-1:0]             grant;
  logic [IDX_W-1:0]               grant_idx;
  logic                           grant_valid;
  logic [NUM_REQ-1:0]             busy_q;
  logic [NUM_REQ-1:0]             rsp_valid_q;
  logic [NUM_REQ-1:0]             rsp_fire;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0]              sel_src1;
  logic [DATA_W-1:0]              sel_src2;
  mul_tag_t [DEPTH-1:0]           tag_pipe;
  mul_tag_t                       tag_in;
  mul_tag_t                       tag_out;

  // busy_q is registered, so a requester freed at an edge competes only
  // from the following cycle.
  assign eligible = req_valid & ~busy_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .reset      (reset),
    .eligible   (eligible),
    .update     (grant_valid),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = req_src1[i*DATA_W +: DATA_W];
        sel_src2 = req_src2[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_valid;
    tag_in.idx   = TAG_IDX_W'(grant_idx);
  end

  assign tag_out = tag_pipe[DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_src1 <= '0;
      mul_src2 <= '0;
      tag_pipe <= '0;
    end else begin
      if (grant_valid) begin
        mul_src1 <= sel_src1;
        mul_src2 <= sel_src2;
      end
      tag_pipe <= {tag_pipe[DEPTH-2:0], tag_in};
    end
  end

  // Capture and consume can never hit the same index in one cycle: busy
  // blocks a re-issue until the held result has been taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data    <= '0;
      busy_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (tag_out.valid && (tag_out.idx == TAG_IDX_W'(i))) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data[i]    <= mul_result;
        end else if (rsp_fire[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
      busy_q <= (busy_q | grant) & ~rsp_fire;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_data;
  assign busy       = busy_q;

endmodule
